// File: rtl/conv_burst_pkg.sv
// Shared types, widths and helpers for the convolution burst read master.
package conv_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH_DEFAULT = 32;
    localparam int FIFO_CNT_W         = $clog2(FIFO_DEPTH_DEFAULT) + 1;

    function automatic int unsigned min_burst(input int unsigned remaining,
                                              input int unsigned max_burst);
        return (remaining < max_burst) ? remaining : max_burst;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head word and an occupancy count.
module sync_fifo
    import conv_burst_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int CNT_W = FIFO_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/conv_burst_read_master.sv
// Avalon-MM burst read initiator: splits a command into bursts, issues them
// under FIFO credit and streams the returned words out in order.
module conv_burst_read_master
    import conv_burst_pkg::*;
#(
    parameter int WIDTHA     = 10,
    parameter int WIDTHD     = 16,
    parameter int WIDTHB     = 8,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic              clock,
    input  logic              clock_areset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTHA-1:0] cmd_address,
    input  logic [WIDTHA:0]   cmd_length,
    output logic [WIDTHA-1:0] avm_address,
    output logic [WIDTHB-1:0] avm_burstcount,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [WIDTHD-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [WIDTHD-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RW    = WIDTHA + 1;

    state_e            state_q, state_d;
    logic [WIDTHA-1:0] addr_q, addr_d;
    logic [RW-1:0]     remaining_q, remaining_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic              avm_read_q, avm_read_d;
    logic [WIDTHA-1:0] avm_address_q, avm_address_d;
    logic [WIDTHB-1:0] avm_burstcount_q, avm_burstcount_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  fifo_count, credit;
    logic              fifo_empty, push, pop, accept, credit_ok;
    logic [RW-1:0]     burst_src;
    logic [WIDTHB-1:0] burst;

    // Stray readdatavalid with nothing outstanding is dropped here.
    assign push      = avm_readdatavalid && (outstanding_q != '0);
    assign pop       = !fifo_empty && st_ready;
    assign accept    = avm_read_q && !avm_waitrequest;
    assign burst_src = (state_q == IDLE) ? cmd_length : remaining_q;
    assign burst     = WIDTHB'(min_burst(32'(burst_src), 32'(MAX_BURST)));
    assign credit    = CNT_W'(FIFO_DEPTH) - fifo_count - outstanding_q;
    assign credit_ok = (32'(credit) >= 32'(burst));

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        outstanding_d    = outstanding_q - CNT_W'(push);
        avm_read_d       = avm_read_q;
        avm_address_d    = avm_address_q;
        avm_burstcount_d = avm_burstcount_q;
        done_d           = 1'b0;
        if (accept) begin
            outstanding_d = outstanding_d + CNT_W'(avm_burstcount_q);
        end
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_address;
                    remaining_d = cmd_length;
                    if (cmd_length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        // Launch the first burst straight from the command.
                        if (credit_ok) begin
                            avm_read_d       = 1'b1;
                            avm_address_d    = cmd_address;
                            avm_burstcount_d = burst;
                        end
                    end
                end
            end
            ISSUE: begin
                if (avm_read_q) begin
                    if (!avm_waitrequest) begin
                        avm_read_d  = 1'b0;
                        addr_d      = addr_q + WIDTHA'(avm_burstcount_q);
                        remaining_d = remaining_q - RW'(avm_burstcount_q);
                        if (remaining_d == '0) begin
                            state_d = DRAIN;
                        end
                    end
                end else if (credit_ok) begin
                    avm_read_d       = 1'b1;
                    avm_address_d    = addr_q;
                    avm_burstcount_d = burst;
                end
            end
            DRAIN: begin
                // Finish on the cycle the last buffered word leaves.
                if (outstanding_q == '0 &&
                    (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            remaining_q      <= '0;
            outstanding_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_address_q    <= '0;
            avm_burstcount_q <= '0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            remaining_q      <= remaining_d;
            outstanding_q    <= outstanding_d;
            avm_read_q       <= avm_read_d;
            avm_address_q    <= avm_address_d;
            avm_burstcount_q <= avm_burstcount_d;
            done_q           <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTHD),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clock),
        .rst_n (clock_areset_n),
        .push  (push),
        .din   (avm_readdata),
        .pop   (pop),
        .dout  (st_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign avm_read       = avm_read_q;
    assign avm_address    = avm_address_q;
    assign avm_burstcount = avm_burstcount_q;
    assign st_valid       = !fifo_empty;
    assign done           = done_q;

endmodule

// File: tb/tb_conv_burst_read_master.sv
// Directed and randomized bench for conv_burst_read_master with a memory
// slave model and a transaction-level reference of bursts and word order.
module tb_conv_burst_read_master;
    localparam int WA = 10;
    localparam int WL = WA + 1;
    localparam int WD = 16;
    localparam int WB = 8;
    localparam int MB = 16;
    localparam int FD = 32;

    logic          clock = 1'b0;
    logic          clock_areset_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [WA-1:0] cmd_address = '0;
    logic [WA:0]   cmd_length = '0;
    logic [WA-1:0] avm_address;
    logic [WB-1:0] avm_burstcount;
    logic          avm_read;
    logic          avm_waitrequest = 1'b0;
    logic [WD-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic [WD-1:0] st_data;
    logic          st_valid;
    logic          st_ready = 1'b1;
    logic          busy;
    logic          done;

    conv_burst_read_master #(
        .WIDTHA(WA), .WIDTHD(WD), .WIDTHB(WB), .MAX_BURST(MB), .FIFO_DEPTH(FD)
    ) dut (
        .clock             (clock),
        .clock_areset_n    (clock_areset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_address       (cmd_address),
        .cmd_length        (cmd_length),
        .avm_address       (avm_address),
        .avm_burstcount    (avm_burstcount),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .st_data           (st_data),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .busy              (busy),
        .done              (done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [WD-1:0] mem [1024];
    int            beat_q[$];
    logic [WD-1:0] exp_words[$];
    logic [31:0]   exp_bursts[$];
    logic [31:0]   got_bursts[$];

    int fifo_m = 0, out_m = 0, done_cnt = 0, stall_cnt = 0, last_acc_bc = 0;
    bit last_push = 0, last_pop = 0, prev_stalled = 0, prev_acc = 0;
    logic [WA-1:0] prev_addr = '0;
    logic [WB-1:0] prev_bc = '0;
    int wr_mode = 0, ready_mode = 0;
    bit rdv_rand = 0, spurious_once = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bkey(input int a, input int b);
        return 32'(a * 256 + b);
    endfunction

    task automatic reset_model();
        beat_q.delete();
        exp_words.delete();
        exp_bursts.delete();
        got_bursts.delete();
        fifo_m = 0; out_m = 0; done_cnt = 0; stall_cnt = 0; last_acc_bc = 0;
        last_push = 0; last_pop = 0; prev_stalled = 0; prev_acc = 0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // One clock: settle the effects of the last edge, check, drive the next.
    task automatic tick();
        bit acc_now, pop_now;
        @(negedge clock);
        if (!clock_areset_n) begin
            avm_readdatavalid = 1'b0;
            avm_waitrequest = 1'b0;
            return;
        end
        out_m += last_acc_bc;
        if (last_push) begin
            out_m--;
            fifo_m++;
        end
        if (last_pop) fifo_m--;
        chk("st_valid", 32'(st_valid), 32'(fifo_m != 0));
        chk("credit_bound", 32'(out_m + fifo_m <= FD), 32'(1));
        if (prev_stalled) begin
            chk("hold_read", 32'(avm_read), 32'(1));
            chk("hold_addr", 32'(avm_address), 32'(prev_addr));
            chk("hold_bc", 32'(avm_burstcount), 32'(prev_bc));
        end
        if (prev_acc) chk("read_gap", 32'(avm_read), 32'(0));
        if (done) begin
            done_cnt++;
            chk("done_busy", 32'(busy), 32'(0));
            chk("done_words_left", 32'(exp_words.size()), 32'(0));
        end

        st_ready = (ready_mode == 0) ? 1'b1 :
                   (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        pop_now = st_valid && st_ready;
        if (pop_now) begin
            chk("word_available", 32'(exp_words.size() != 0), 32'(1));
            if (exp_words.size() != 0) begin
                logic [WD-1:0] e;
                e = exp_words.pop_front();
                chk("st_data", 32'(st_data), 32'(e));
            end
        end

        avm_readdatavalid = 1'b0;
        avm_readdata = WD'($urandom);
        if (beat_q.size() > 0 && (!rdv_rand || $urandom_range(0, 3) != 0)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = mem[beat_q.pop_front()];
        end else if (spurious_once && beat_q.size() == 0) begin
            avm_readdatavalid = 1'b1;
            spurious_once = 0;
        end
        last_push = avm_readdatavalid && (out_m != 0);

        if (wr_mode < 0) avm_waitrequest = ($urandom_range(0, 2) == 0);
        else avm_waitrequest = avm_read && (stall_cnt < wr_mode);
        acc_now = avm_read && !avm_waitrequest;
        if (acc_now) begin
            for (int i = 0; i < int'(avm_burstcount); i++)
                beat_q.push_back((int'(avm_address) + i) % 1024);
            got_bursts.push_back(bkey(int'(avm_address), int'(avm_burstcount)));
            stall_cnt = 0;
            last_acc_bc = int'(avm_burstcount);
        end else begin
            last_acc_bc = 0;
            if (avm_read) stall_cnt++;
        end
        prev_stalled = avm_read && avm_waitrequest;
        prev_acc = acc_now;
        prev_addr = avm_address;
        prev_bc = avm_burstcount;
        last_pop = pop_now;
    endtask

    task automatic start_cmd(input int addr, input int len);
        int a, r;
        a = addr;
        r = len;
        exp_bursts.delete();
        got_bursts.delete();
        done_cnt = 0;
        for (int i = 0; i < len; i++) exp_words.push_back(mem[(addr + i) % 1024]);
        while (r > 0) begin
            int b;
            b = (r < MB) ? r : MB;
            exp_bursts.push_back(bkey(a, b));
            a = (a + b) % 1024;
            r -= b;
        end
        chk("cmd_ready", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_address = WA'(addr);
        cmd_length = WL'(len);
        tick();
        cmd_valid = 1'b0;
        chk("busy_after_cmd", 32'(busy), 32'(len != 0));
        chk("read_latency", 32'(avm_read), 32'(len != 0));
        if (len != 0) chk("first_addr", 32'(avm_address), 32'(addr));
        $display("cmd addr=0x%03h len=%0d bursts=%0d", addr, len, exp_bursts.size());
    endtask

    task automatic finish_cmd(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt), 32'(1));
        tick();
        tick();
        chk("done_once", 32'(done_cnt), 32'(1));
        chk("words_left", 32'(exp_words.size()), 32'(0));
        chk("burst_count", 32'(got_bursts.size()), 32'(exp_bursts.size()));
        for (int i = 0; i < exp_bursts.size() && i < got_bursts.size(); i++)
            chk("burst", got_bursts[i], exp_bursts[i]);
        chk("idle_busy", 32'(busy), 32'(0));
        $display("cmd complete after %0d cycles, %0d bursts issued", n, got_bursts.size());
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = WD'($urandom);

        #1 clock_areset_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_avm_read", 32'(avm_read), 32'(0));
        chk("rst_avm_address", 32'(avm_address), 32'(0));
        chk("rst_avm_burstcount", 32'(avm_burstcount), 32'(0));
        chk("rst_st_valid", 32'(st_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        tick();
        tick();
        clock_areset_n = 1'b1;
        tick();

        // Split into bursts with one waitrequest cycle per read.
        wr_mode = 1; ready_mode = 0; rdv_rand = 0;
        start_cmd(32'h010, 40);
        finish_cmd(500);

        // Zero length, plus a stray readdatavalid that must be ignored.
        wr_mode = 0;
        start_cmd(32'h055, 0);
        chk("zero_done", 32'(done), 32'(1));
        chk("zero_read", 32'(avm_read), 32'(0));
        spurious_once = 1;
        finish_cmd(10);

        // Backpressure: credit must stop issue at two bursts.
        ready_mode = 1;
        start_cmd(32'h200, 64);
        repeat (120) tick();
        chk("bp_bursts", 32'(got_bursts.size()), 32'(2));
        chk("bp_read_idle", 32'(avm_read), 32'(0));
        chk("bp_fifo_full", 32'(fifo_m), 32'(FD));
        chk("bp_outstanding", 32'(out_m), 32'(0));
        ready_mode = 0;
        finish_cmd(500);

        // Address wrap inside one burst.
        ready_mode = 2; rdv_rand = 1;
        start_cmd(32'h3F8, 16);
        finish_cmd(500);

        // Long waitrequest stall.
        wr_mode = 5; ready_mode = 0; rdv_rand = 0;
        start_cmd(32'h0A0, 16);
        finish_cmd(500);

        // Reset mid-burst, then a fresh command.
        wr_mode = -1; ready_mode = 2; rdv_rand = 1;
        start_cmd(32'h123, 40);
        repeat (10) tick();
        clock_areset_n = 1'b0;
        reset_model();
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("mid_rst_avm_read", 32'(avm_read), 32'(0));
        chk("mid_rst_avm_address", 32'(avm_address), 32'(0));
        chk("mid_rst_avm_burstcount", 32'(avm_burstcount), 32'(0));
        chk("mid_rst_st_valid", 32'(st_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        tick();
        tick();
        clock_areset_n = 1'b1;
        tick();
        start_cmd(32'h300, 33);
        finish_cmd(2000);

        // Randomized commands and slave/stream behaviour.
        for (int k = 0; k < 6; k++) begin
            wr_mode = int'($urandom_range(0, 3)) - 1;
            ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            rdv_rand = 1'($urandom_range(0, 1));
            start_cmd(int'($urandom_range(0, 1023)), int'($urandom_range(1, 100)));
            finish_cmd(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
